// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//
// Purpose:
//   Shares a single external cycle counter (load/enable/d/q, wrapping at MAX)
//   between up to N requesters. Each requester asks for a timed slot of `len`
//   cycles. The block arbitrates round-robin and loads the counter with zero.
//   It then enables the counter until q reaches L-1, and finally returns a
//   one-cycle `done` pulse to the owning requester.
//
// Parameters:
//   N    number of requesters (2..8)
//   W    counter width, equal to the width of the counter's d/q
//   MAX  wrap value of the attached counter
//
// Ports:
//   clock       in   1    rising-edge clock
//   reset       in   1    asynchronous, active-low reset
//   req         in   N    per-requester level request
//   len         in   N*W  per-requester slot length, requester i uses [i*W +: W]
//   gnt         out  N    one-hot owner of the counter, zero when idle
//   done        out  N    one-cycle completion pulse to the owner
//   busy        out  1    high whenever the FSM is not idle
//   cnt_d       out  W    counter load value (always zero)
//   cnt_load    out  1    counter load strobe
//   cnt_enable  out  1    counter count enable
//   cnt_q       in   W    counter current value
// -----------------------------------------------------------------------------
module counter_arbiter #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int MAX = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   len,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic             busy,
    output logic [W-1:0]     cnt_d,
    output logic             cnt_load,
    output logic             cnt_enable,
    input  logic [W-1:0]     cnt_q
);

    localparam int IW = $clog2(N);

    // Largest terminal count a slot may use. Clamping L to MAX+1 makes the
    // terminal count L-1 at most MAX, so the counter never wraps inside a slot.
    localparam logic [W-1:0] MAX_W = W'(MAX);
    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    logic [IW-1:0]      r_own;      // index of the current owner
    logic [IW-1:0]      r_last;     // most recent owner, the round-robin pointer
    logic [W-1:0]       r_lim;      // terminal count L-1 for the current slot

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [N-1:0][W-1:0] w_lim;     // per-requester terminal count L-1
    logic [N-1:0]        w_own_1h;  // one-hot decode of r_own
    logic [IW-1:0]       w_pick;    // round-robin winner
    logic                w_pick_valid;
    logic                w_own_req; // owner still requesting
    logic                w_withdraw;
    logic                w_grant;
    logic                w_at_end;

    // Effective terminal count per requester:
    //   len == 0          -> L = 1      -> L-1 = 0
    //   len-1 > MAX       -> L = MAX+1  -> L-1 = MAX
    //   otherwise                       -> L-1 = len-1
    // This is computed for every requester in parallel, so the grant cycle
    // only has to select one entry.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lim
            logic [W-1:0] w_len_i;
            logic [W-1:0] w_len_m1;

            assign w_len_i  = len[gi*W +: W];
            assign w_len_m1 = w_len_i - ONE_W;
            assign w_lim[gi] = (w_len_i == '0)      ? '0    :
                               (w_len_m1 > MAX_W)   ? MAX_W :
                                                      w_len_m1;
        end
    endgenerate

    // One-hot owner decode, which gnt and done share.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_own_1h
            assign w_own_1h[gi] = (r_own == IW'(gi));
        end
    endgenerate

    // Round-robin search starting at r_last+1 (mod N). The loop runs from
    // the farthest candidate to the nearest one. A later match overwrites an
    // earlier one, so the requester closest after r_last wins.
    always_comb begin
        logic [IW:0] v_sum;
        w_pick       = '0;
        w_pick_valid = 1'b0;
        v_sum        = '0;
        for (int k = N; k >= 1; k--) begin
            v_sum = {1'b0, r_last} + (IW+1)'(k);
            if (v_sum >= (IW+1)'(N)) begin
                v_sum = v_sum - (IW+1)'(N);
            end
            if (req[v_sum[IW-1:0]]) begin
                w_pick       = v_sum[IW-1:0];
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_own_req  = req[r_own];
    // A withdrawal is only honoured while the slot is still in progress.
    // Once in DONE, the slot has completed regardless of req.
    assign w_withdraw = ((r_state == S_LOAD) || (r_state == S_RUN)) && !w_own_req;
    assign w_grant    = (r_state == S_IDLE) && w_pick_valid;
    // cnt_q is only meaningful in RUN. During LOAD it still holds a stale value.
    assign w_at_end   = (r_state == S_RUN) && (cnt_q == r_lim);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_own_req) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Withdrawal wins over completion. A requester that dropped
                // its request gets no done pulse.
                if (!w_own_req) begin
                    w_state_next = S_IDLE;
                end else if (w_at_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        gnt        = '0;
        done       = '0;
        busy       = 1'b0;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        cnt_d      = '0;
        case (r_state)
            S_IDLE: begin
                gnt  = '0;
                busy = 1'b0;
            end
            S_LOAD: begin
                gnt      = w_own_1h;
                busy     = 1'b1;
                cnt_load = 1'b1;
            end
            S_RUN: begin
                gnt        = w_own_1h;
                busy       = 1'b1;
                cnt_enable = 1'b1;
            end
            S_DONE: begin
                gnt  = w_own_1h;
                done = w_own_1h;
                busy = 1'b1;
            end
            default: begin
                gnt  = '0;
                busy = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: owner, terminal count and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_own  <= '0;
            r_lim  <= '0;
            // Pointing at the last requester makes requester 0 win first.
            r_last <= IW'(N-1);
        end else begin
            if (w_grant) begin
                r_own <= w_pick;
                r_lim <= w_lim[w_pick];
            end
            // The pointer advances both on completion and on withdrawal. A
            // requester that keeps req high therefore cannot starve the others.
            if ((r_state == S_DONE) || w_withdraw) begin
                r_last <= r_own;
            end
        end
    end

endmodule
